hyperbus_burst_splitter: RTL and testbench

Splits each upstream HyperBus transfer descriptor (`hyper_tf_t`) into sub-bursts no longer than the configured maximum chip-select time (`t_burst_max`), so the PHY never holds CS_N low beyond t_CSM. Sits between the AXI-side transfer generator and the PHY controller. Each sub-burst is emitted as a complete `hyper_tf_t`, flagged `last` on the final piece.

---
 rtl/hyperbus_burst_splitter.sv | 191 +++++++++++++++++++
 tb/tb_hyperbus_burst_splitter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_burst_splitter.sv
// Splits HyperBus transfer descriptors into sub-bursts no longer than t_burst_max words,
// so that CS_N is never held low beyond t_CSM. Optional macro: HYPERBUS_SPLITTER_PIPE_EN.
module hyperbus_burst_splitter #(
    // Matches hyperbus_pkg::HyperBurstWidth.
    parameter int unsigned BurstWidth = 15,
    localparam int unsigned TfWidth = BurstWidth + 35
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [15:0]        cfg_burst_max_i,
    input  logic               in_tf_valid_i,
    output logic               in_tf_ready_o,
    input  logic [TfWidth-1:0] in_tf_i,
    output logic               out_tf_valid_o,
    input  logic               out_tf_ready_i,
    output logic [TfWidth-1:0] out_tf_o,
    output logic               out_last_o,
    output logic               busy_o
);

    // Descriptor layout, MSB first: write, burst, burst_type, address_space, address.
    localparam int unsigned WriteBit = BurstWidth + 34;
    localparam int unsigned BurstMsb = BurstWidth + 33;
    localparam int unsigned BurstLsb = 34;
    localparam int unsigned TypeBit  = 33;
    localparam int unsigned SpaceBit = 32;

    typedef enum logic [0:0] {
        Idle = 1'b0,
        Emit = 1'b1
    } state_e;

    // Wrapped bursts and an unlimited (zero) maximum are never split.
    function automatic logic [BurstWidth-1:0] chunk_f(
        input logic [BurstWidth-1:0] rem,
        input logic [15:0]           max,
        input logic                  linear
    );
        logic [BurstWidth-1:0] res;
        if ((max == 16'd0) || !linear || (32'(rem) <= 32'(max))) begin
            res = rem;
        end else begin
            res = max[BurstWidth-1:0];
        end
        return res;
    endfunction

    function automatic logic [TfWidth-1:0] pack_f(
        input logic                  write,
        input logic [BurstWidth-1:0] burst,
        input logic                  linear,
        input logic                  space,
        input logic [31:0]           addr
    );
        return {write, burst, linear, space, addr};
    endfunction

    state_e                state_r;
    logic                  write_r;
    logic                  linear_r;
    logic                  space_r;
    logic [BurstWidth-1:0] rem_r;
    logic [31:0]           addr_r;
    logic [15:0]           max_r;
    logic [TfWidth-1:0]    out_tf_r;
    logic                  out_last_r;
    logic                  out_valid_r;
    logic                  busy_r;
    logic                  ready_r;

    logic                  in_write_s;
    logic                  in_linear_s;
    logic                  in_space_s;
    logic [BurstWidth-1:0] in_burst_s;
    logic [31:0]           in_addr_s;
    logic [BurstWidth-1:0] in_chunk_s;
    logic [BurstWidth-1:0] out_burst_s;
    logic [BurstWidth-1:0] rem_next_s;
    logic [31:0]           addr_next_s;
    logic [BurstWidth-1:0] next_chunk_s;
    logic                  hs_s;
    logic                  take_s;

`ifdef HYPERBUS_SPLITTER_PIPE_EN
    // A new parent may be taken in the same cycle the final piece of the current one leaves.
    assign in_tf_ready_o = ready_r | (out_valid_r & out_last_r & out_tf_ready_i);
`else
    assign in_tf_ready_o = ready_r;
`endif

    assign out_tf_valid_o = out_valid_r;
    assign out_tf_o       = out_tf_r;
    assign out_last_o     = out_last_r;
    assign busy_o         = busy_r;

    // Field extraction and next-piece arithmetic for both the load and advance paths.
    always_comb begin
        in_write_s   = in_tf_i[WriteBit];
        in_burst_s   = in_tf_i[BurstMsb:BurstLsb];
        in_linear_s  = in_tf_i[TypeBit];
        in_space_s   = in_tf_i[SpaceBit];
        in_addr_s    = in_tf_i[31:0];
        in_chunk_s   = chunk_f(in_burst_s, cfg_burst_max_i, in_linear_s);
        out_burst_s  = out_tf_r[BurstMsb:BurstLsb];
        rem_next_s   = rem_r - out_burst_s;
        addr_next_s  = addr_r + 32'(out_burst_s);
        next_chunk_s = chunk_f(rem_next_s, max_r, linear_r);
        hs_s         = out_valid_r & out_tf_ready_i;
        take_s       = in_tf_valid_i & in_tf_ready_o;
    end

    // Splitter FSM; every output is registered and precomputed for the piece it presents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= Idle;
            write_r     <= 1'b0;
            linear_r    <= 1'b0;
            space_r     <= 1'b0;
            rem_r       <= '0;
            addr_r      <= 32'd0;
            max_r       <= 16'd0;
            out_tf_r    <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            case (state_r)
                Idle: begin
                    if (take_s) begin
                        state_r     <= Emit;
                        write_r     <= in_write_s;
                        linear_r    <= in_linear_s;
                        space_r     <= in_space_s;
                        rem_r       <= in_burst_s;
                        addr_r      <= in_addr_s;
                        max_r       <= cfg_burst_max_i;
                        out_tf_r    <= pack_f(in_write_s, in_chunk_s, in_linear_s,
                                              in_space_s, in_addr_s);
                        out_last_r  <= (in_burst_s == in_chunk_s);
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        ready_r     <= 1'b0;
                    end else begin
                        state_r <= Idle;
                    end
                end
                Emit: begin
                    if (take_s) begin
                        // Only reachable with the pipelined handoff enabled.
                        state_r     <= Emit;
                        write_r     <= in_write_s;
                        linear_r    <= in_linear_s;
                        space_r     <= in_space_s;
                        rem_r       <= in_burst_s;
                        addr_r      <= in_addr_s;
                        max_r       <= cfg_burst_max_i;
                        out_tf_r    <= pack_f(in_write_s, in_chunk_s, in_linear_s,
                                              in_space_s, in_addr_s);
                        out_last_r  <= (in_burst_s == in_chunk_s);
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        ready_r     <= 1'b0;
                    end else if (hs_s && out_last_r) begin
                        state_r     <= Idle;
                        out_last_r  <= 1'b0;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        ready_r     <= 1'b1;
                    end else if (hs_s) begin
                        rem_r      <= rem_next_s;
                        addr_r     <= addr_next_s;
                        out_tf_r   <= pack_f(write_r, next_chunk_s, linear_r,
                                             space_r, addr_next_s);
                        out_last_r <= (rem_next_s == next_chunk_s);
                    end else begin
                        state_r <= Emit;
                    end
                end
                default: begin
                    state_r     <= Idle;
                    out_last_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    ready_r     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// Directed testbench for hyperbus_burst_splitter; expected pieces are hand-computed per vector.
module tb_hyperbus_burst_splitter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] cfg_burst_max_i;
    logic        in_tf_valid_i;
    logic        in_tf_ready_o;
    logic [49:0] in_tf_i;
    logic        out_tf_valid_o;
    logic        out_tf_ready_i;
    logic [49:0] out_tf_o;
    logic        out_last_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    logic p_write;
    logic p_linear;
    logic p_space;

    hyperbus_burst_splitter dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cfg_burst_max_i (cfg_burst_max_i),
        .in_tf_valid_i   (in_tf_valid_i),
        .in_tf_ready_o   (in_tf_ready_o),
        .in_tf_i         (in_tf_i),
        .out_tf_valid_o  (out_tf_valid_o),
        .out_tf_ready_i  (out_tf_ready_i),
        .out_tf_o        (out_tf_o),
        .out_last_o      (out_last_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [49:0] mk(input logic w, input logic [14:0] b, input logic lin,
                                       input logic sp, input logic [31:0] a);
        return {w, b, lin, sp, a};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_piece(input string tag, input logic [31:0] a, input logic [14:0] b,
                               input logic last);
        check_eq({tag, "_valid"}, 64'(out_tf_valid_o), 64'd1);
        check_eq({tag, "_tf"}, 64'(out_tf_o), 64'(mk(p_write, b, p_linear, p_space, a)));
        check_eq({tag, "_last"}, 64'(out_last_o), 64'(last));
        check_eq({tag, "_busy"}, 64'(busy_o), 64'd1);
    endtask

    task automatic exp_piece(input string tag, input logic [31:0] a, input logic [14:0] b,
                             input logic last);
        check_piece(tag, a, b, last);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic exp_idle(input string tag);
        check_eq({tag, "_idle_valid"}, 64'(out_tf_valid_o), 64'd0);
        check_eq({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
        check_eq({tag, "_idle_ready"}, 64'(in_tf_ready_o), 64'd1);
    endtask

    task automatic send(input string tag, input logic w, input logic [14:0] b, input logic lin,
                        input logic sp, input logic [31:0] a, input logic [15:0] mx);
        p_write  = w;
        p_linear = lin;
        p_space  = sp;
        check_eq({tag, "_accept_ready"}, 64'(in_tf_ready_o), 64'd1);
        in_tf_valid_i   = 1'b1;
        in_tf_i         = mk(w, b, lin, sp, a);
        cfg_burst_max_i = mx;
        @(posedge clk_i);
        @(negedge clk_i);
        in_tf_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_i           = 1'b1;
        cfg_burst_max_i = 16'd0;
        in_tf_valid_i   = 1'b0;
        in_tf_i         = 50'd0;
        out_tf_ready_i  = 1'b1;
        p_write         = 1'b0;
        p_linear        = 1'b1;
        p_space         = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_ready", 64'(in_tf_ready_o), 64'd1);
        check_eq("rst_valid", 64'(out_tf_valid_o), 64'd0);
        check_eq("rst_last", 64'(out_last_o), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_tf", 64'(out_tf_o), 64'd0);
        rst_i = 1'b0;

        // Linear 10 words split by 4.
        send("t1", 1'b0, 15'd10, 1'b1, 1'b0, 32'h0000_0100, 16'd4);
        exp_piece("t1_p0", 32'h0000_0100, 15'd4, 1'b0);
        exp_piece("t1_p1", 32'h0000_0104, 15'd4, 1'b0);
        exp_piece("t1_p2", 32'h0000_0108, 15'd2, 1'b1);
        exp_idle("t1");

        // Exactly the maximum: one piece, fields copied.
        send("t2", 1'b1, 15'd8, 1'b1, 1'b1, 32'h0000_2000, 16'd8);
        exp_piece("t2_p0", 32'h0000_2000, 15'd8, 1'b1);
        exp_idle("t2");

        // Unlimited maximum.
        send("t3", 1'b0, 15'd300, 1'b1, 1'b0, 32'h0000_0040, 16'd0);
        exp_piece("t3_p0", 32'h0000_0040, 15'd300, 1'b1);
        exp_idle("t3");

        // Wrapped bursts are never split.
        send("t4", 1'b1, 15'd16, 1'b0, 1'b0, 32'h0000_0080, 16'd4);
        exp_piece("t4_p0", 32'h0000_0080, 15'd16, 1'b1);
        exp_idle("t4");

        // Zero-length burst forwarded once.
        send("t5", 1'b0, 15'd0, 1'b1, 1'b0, 32'h0000_0090, 16'd4);
        exp_piece("t5_p0", 32'h0000_0090, 15'd0, 1'b1);
        exp_idle("t5");

        // Address wrap, with max changed after accept.
        send("t6", 1'b0, 15'd4, 1'b1, 1'b1, 32'hFFFF_FFFE, 16'd2);
        cfg_burst_max_i = 16'd1;
        exp_piece("t6_p0", 32'hFFFF_FFFE, 15'd2, 1'b0);
        exp_piece("t6_p1", 32'h0000_0000, 15'd2, 1'b1);
        exp_idle("t6");

        // Backpressure on the second piece.
        send("t7", 1'b1, 15'd10, 1'b1, 1'b0, 32'h0000_0200, 16'd4);
        exp_piece("t7_p0", 32'h0000_0200, 15'd4, 1'b0);
        out_tf_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_piece("t7_hold", 32'h0000_0204, 15'd4, 1'b0);
        end
        out_tf_ready_i = 1'b1;
        exp_piece("t7_p1", 32'h0000_0204, 15'd4, 1'b0);
        exp_piece("t7_p2", 32'h0000_0208, 15'd2, 1'b1);
        exp_idle("t7");

        // Back-to-back parents.
        send("t8a", 1'b0, 15'd2, 1'b1, 1'b0, 32'h0000_0500, 16'd0);
        check_piece("t8a_p0", 32'h0000_0500, 15'd2, 1'b1);
        in_tf_valid_i   = 1'b1;
        in_tf_i         = mk(1'b0, 15'd4, 1'b1, 1'b0, 32'h0000_0600);
        cfg_burst_max_i = 16'd2;
        #1;
`ifdef HYPERBUS_SPLITTER_PIPE_EN
        check_eq("t8_ready_on_last", 64'(in_tf_ready_o), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        in_tf_valid_i = 1'b0;
`else
        check_eq("t8_ready_on_last", 64'(in_tf_ready_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("t8_gap_valid", 64'(out_tf_valid_o), 64'd0);
        check_eq("t8_gap_ready", 64'(in_tf_ready_o), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        in_tf_valid_i = 1'b0;
`endif
        exp_piece("t8b_p0", 32'h0000_0600, 15'd2, 1'b0);
        exp_piece("t8b_p1", 32'h0000_0602, 15'd2, 1'b1);
        exp_idle("t8");

        // Reset during the second piece of a three-piece parent.
        send("t9", 1'b0, 15'd12, 1'b1, 1'b0, 32'h0000_0300, 16'd4);
        exp_piece("t9_p0", 32'h0000_0300, 15'd4, 1'b0);
        check_piece("t9_p1", 32'h0000_0304, 15'd4, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("t9_rst_valid", 64'(out_tf_valid_o), 64'd0);
        check_eq("t9_rst_ready", 64'(in_tf_ready_o), 64'd1);
        check_eq("t9_rst_busy", 64'(busy_o), 64'd0);
        check_eq("t9_rst_last", 64'(out_last_o), 64'd0);
        rst_i = 1'b0;

        send("t10", 1'b1, 15'd3, 1'b1, 1'b0, 32'h0000_0400, 16'd4);
        exp_piece("t10_p0", 32'h0000_0400, 15'd3, 1'b1);
        exp_idle("t10");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
